// File: rtl/fifo_sync_ext.sv
`default_nettype none
// ============================================================================
// Module  : fifo_sync_ext
// Brief   : Single-clock FIFO with standard/FWFT read, threshold flags and
//           sticky overflow/underflow errors.
// Revision: 1.0
// ============================================================================
module fifo_sync_ext #(
    parameter int DATA_WIDTH    = 32,
    parameter int MEMORY_DEPTH  = 16,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = 14,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr,
    input  logic [DATA_WIDTH-1:0]           din,
    input  logic                            rd,
    output logic [DATA_WIDTH-1:0]           dout,
    output logic                            dout_valid,
    output logic                            empty,
    output logic                            full,
    output logic                            almost_empty,
    output logic                            almost_full,
    output logic [$clog2(MEMORY_DEPTH):0]   count,
    output logic                            overflow,
    output logic                            underflow,
    input  logic                            clr_err
);

    localparam int c_aw = $clog2(MEMORY_DEPTH);
    localparam int c_pw = c_aw + 1;
    localparam logic [c_pw-1:0] c_depth  = c_pw'(MEMORY_DEPTH);
    localparam logic [c_pw-1:0] c_afull  = c_pw'(AFULL_THRESH);
    localparam logic [c_pw-1:0] c_aempty = c_pw'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [MEMORY_DEPTH];

    logic [c_pw-1:0] wptr_q, wptr_d;
    logic [c_pw-1:0] rptr_q, rptr_d;
    logic            ovf_q, ovf_d;
    logic            udf_q, udf_d;

    logic [c_pw-1:0] w_count;
    logic            w_empty;
    logic            w_full;
    logic            w_wr_acc;
    logic            w_rd_acc;

    // The wrap bit makes the pointer difference span 0..MEMORY_DEPTH exactly,
    // so the occupancy moves on the same edge as the accepted access.
    assign w_count  = wptr_q - rptr_q;
    assign w_empty  = (w_count == '0);
    assign w_full   = (w_count == c_depth);
    assign w_wr_acc = wr & ~w_full;
    assign w_rd_acc = rd & ~w_empty;

    assign count        = w_count;
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_empty = (w_count <= c_aempty);
    assign almost_full  = (w_count >= c_afull);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ovf_d  = ovf_q & ~clr_err;
        udf_d  = udf_q & ~clr_err;
        if (w_wr_acc) begin
            wptr_d = wptr_q + c_pw'(1);
        end
        if (w_rd_acc) begin
            rptr_d = rptr_q + c_pw'(1);
        end
        // A new error in the same cycle as clr_err wins over the clear.
        if (wr && w_full) begin
            ovf_d = 1'b1;
        end
        if (rd && w_empty) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            mem_q[wptr_q[c_aw-1:0]] <= din;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign dout       = mem_q[rptr_q[c_aw-1:0]];
            assign dout_valid = ~w_empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;
            logic                  dout_valid_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_q       <= '0;
                    dout_valid_q <= 1'b0;
                end else begin
                    dout_valid_q <= w_rd_acc;
                    if (w_rd_acc) begin
                        dout_q <= mem_q[rptr_q[c_aw-1:0]];
                    end
                end
            end

            assign dout       = dout_q;
            assign dout_valid = dout_valid_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_ext.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_sync_ext
// Brief   : Directed self-checking bench; instance a is standard read, b is FWFT.
// Revision: 1.0
// ============================================================================
module tb_fifo_sync_ext;

    logic       clk;
    logic       rst;

    logic       a_wr, a_rd, a_clr;
    logic [7:0] a_din, a_dout;
    logic       a_dv, a_empty, a_full, a_ae, a_af, a_ovf, a_udf;
    logic [4:0] a_cnt;

    logic       b_wr, b_rd, b_clr;
    logic [7:0] b_din, b_dout;
    logic       b_dv, b_empty, b_full, b_ae, b_af, b_ovf, b_udf;
    logic [4:0] b_cnt;

    int tests_run;
    int failed;

    fifo_sync_ext #(
        .DATA_WIDTH(8), .MEMORY_DEPTH(16), .FWFT(0), .AFULL_THRESH(14), .AEMPTY_THRESH(2)
    ) u_std (
        .clk(clk), .rst(rst), .wr(a_wr), .din(a_din), .rd(a_rd),
        .dout(a_dout), .dout_valid(a_dv), .empty(a_empty), .full(a_full),
        .almost_empty(a_ae), .almost_full(a_af), .count(a_cnt),
        .overflow(a_ovf), .underflow(a_udf), .clr_err(a_clr)
    );

    fifo_sync_ext #(
        .DATA_WIDTH(8), .MEMORY_DEPTH(16), .FWFT(1), .AFULL_THRESH(14), .AEMPTY_THRESH(2)
    ) u_fwft (
        .clk(clk), .rst(rst), .wr(b_wr), .din(b_din), .rd(b_rd),
        .dout(b_dout), .dout_valid(b_dv), .empty(b_empty), .full(b_full),
        .almost_empty(b_ae), .almost_full(b_af), .count(b_cnt),
        .overflow(b_ovf), .underflow(b_udf), .clr_err(b_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #12;
        tests_run++; if (a_cnt !== 5'd0) begin failed++; $display("FAIL reset_count: got %0d exp 0", a_cnt); end
        tests_run++; if (a_empty !== 1'b1 || a_full !== 1'b0) begin failed++; $display("FAIL reset_empty_full: got e=%b f=%b exp e=1 f=0", a_empty, a_full); end
        tests_run++; if (a_ae !== 1'b1 || a_af !== 1'b0) begin failed++; $display("FAIL reset_almost: got ae=%b af=%b exp ae=1 af=0", a_ae, a_af); end
        tests_run++; if (a_ovf !== 1'b0 || a_udf !== 1'b0) begin failed++; $display("FAIL reset_err: got ovf=%b udf=%b exp 0 0", a_ovf, a_udf); end
        tests_run++; if (a_dout !== 8'h00 || a_dv !== 1'b0) begin failed++; $display("FAIL reset_dout: got %h/%b exp 00/0", a_dout, a_dv); end
        tests_run++; if (b_dv !== 1'b0 || b_empty !== 1'b1 || b_cnt !== 5'd0) begin failed++; $display("FAIL reset_fwft: got dv=%b e=%b c=%0d exp 0 1 0", b_dv, b_empty, b_cnt); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_fill;
        for (int i = 0; i < 16; i++) begin
            a_wr  = 1'b1;
            a_din = 8'(i);
            step();
            tests_run++; if (a_cnt !== 5'(i + 1)) begin failed++; $display("FAIL fill_count[%0d]: got %0d exp %0d", i, a_cnt, i + 1); end
            tests_run++; if (a_full !== (i == 15) || a_empty !== 1'b0) begin failed++; $display("FAIL fill_full[%0d]: got f=%b e=%b exp f=%b e=0", i, a_full, a_empty, (i == 15)); end
            tests_run++; if (a_af !== (i + 1 >= 14) || a_ae !== (i + 1 <= 2)) begin failed++; $display("FAIL fill_almost[%0d]: got af=%b ae=%b exp af=%b ae=%b", i, a_af, a_ae, (i + 1 >= 14), (i + 1 <= 2)); end
        end
        a_din = 8'hEE;
        step();
        a_wr = 1'b0;
        tests_run++; if (a_ovf !== 1'b1) begin failed++; $display("FAIL fill_overflow: got %b exp 1", a_ovf); end
        tests_run++; if (a_cnt !== 5'd16 || a_full !== 1'b1) begin failed++; $display("FAIL fill_hold: got c=%0d f=%b exp 16 1", a_cnt, a_full); end
    endtask

    task automatic test_drain_std;
        a_rd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            tests_run++; if (a_dout !== 8'(i) || a_dv !== 1'b1) begin failed++; $display("FAIL drain_data[%0d]: got %h/%b exp %h/1", i, a_dout, a_dv, 8'(i)); end
            tests_run++; if (a_cnt !== 5'(15 - i)) begin failed++; $display("FAIL drain_count[%0d]: got %0d exp %0d", i, a_cnt, 15 - i); end
        end
        a_rd = 1'b0;
        tests_run++; if (a_empty !== 1'b1) begin failed++; $display("FAIL drain_empty: got %b exp 1", a_empty); end
        step();
        tests_run++; if (a_dv !== 1'b0) begin failed++; $display("FAIL drain_valid_pulse: got %b exp 0", a_dv); end
        a_rd = 1'b1;
        step();
        a_rd = 1'b0;
        tests_run++; if (a_udf !== 1'b1) begin failed++; $display("FAIL drain_underflow: got %b exp 1", a_udf); end
        tests_run++; if (a_dout !== 8'd15 || a_dv !== 1'b0 || a_cnt !== 5'd0) begin failed++; $display("FAIL drain_hold: got %h/%b c=%0d exp 0f/0 c=0", a_dout, a_dv, a_cnt); end
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        tests_run++; if (a_ovf !== 1'b0 || a_udf !== 1'b0) begin failed++; $display("FAIL drain_clr: got ovf=%b udf=%b exp 0 0", a_ovf, a_udf); end
    endtask

    // Pointers start at 16 here, so 25 more writes carry the wrap bit over.
    task automatic test_simul_wrap;
        for (int i = 0; i < 5; i++) begin
            a_wr  = 1'b1;
            a_din = 8'(100 + i);
            step();
        end
        a_rd = 1'b1;
        for (int k = 0; k < 20; k++) begin
            a_din = 8'(105 + k);
            step();
            tests_run++; if (a_dout !== 8'(100 + k) || a_dv !== 1'b1) begin failed++; $display("FAIL wrap_data[%0d]: got %0d/%b exp %0d/1", k, a_dout, a_dv, 100 + k); end
            tests_run++; if (a_cnt !== 5'd5) begin failed++; $display("FAIL wrap_count[%0d]: got %0d exp 5", k, a_cnt); end
        end
        a_wr = 1'b0;
        a_rd = 1'b0;
    endtask

    task automatic test_err_simul;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            a_wr  = 1'b1;
            a_din = 8'(8'h40 + i);
            step();
        end
        a_rd  = 1'b1;
        a_din = 8'hFF;
        step();
        a_wr = 1'b0;
        a_rd = 1'b0;
        tests_run++; if (a_cnt !== 5'd15 || a_full !== 1'b0) begin failed++; $display("FAIL full_simul_count: got %0d f=%b exp 15 0", a_cnt, a_full); end
        tests_run++; if (a_ovf !== 1'b1) begin failed++; $display("FAIL full_simul_ovf: got %b exp 1", a_ovf); end
        tests_run++; if (a_dout !== 8'h40 || a_dv !== 1'b1) begin failed++; $display("FAIL full_simul_data: got %h/%b exp 40/1", a_dout, a_dv); end
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        tests_run++; if (a_ovf !== 1'b0) begin failed++; $display("FAIL full_simul_clr: got %b exp 0", a_ovf); end

        do_reset();
        a_wr  = 1'b1;
        a_rd  = 1'b1;
        a_din = 8'h77;
        step();
        a_wr = 1'b0;
        a_rd = 1'b0;
        tests_run++; if (a_cnt !== 5'd1 || a_empty !== 1'b0) begin failed++; $display("FAIL empty_simul_count: got %0d e=%b exp 1 0", a_cnt, a_empty); end
        tests_run++; if (a_udf !== 1'b1 || a_dv !== 1'b0) begin failed++; $display("FAIL empty_simul_udf: got udf=%b dv=%b exp 1 0", a_udf, a_dv); end
        a_rd = 1'b1;
        step();
        a_rd = 1'b0;
        tests_run++; if (a_dout !== 8'h77 || a_dv !== 1'b1 || a_cnt !== 5'd0) begin failed++; $display("FAIL empty_simul_data: got %h/%b c=%0d exp 77/1 c=0", a_dout, a_dv, a_cnt); end
        a_clr = 1'b1;
        step();
        tests_run++; if (a_udf !== 1'b0 || a_ovf !== 1'b0) begin failed++; $display("FAIL empty_simul_clr: got udf=%b ovf=%b exp 0 0", a_udf, a_ovf); end
        a_rd = 1'b1;
        step();
        a_rd = 1'b0;
        tests_run++; if (a_udf !== 1'b1) begin failed++; $display("FAIL set_beats_clr: got %b exp 1", a_udf); end
        step();
        a_clr = 1'b0;
        tests_run++; if (a_udf !== 1'b0) begin failed++; $display("FAIL clr_after_set: got %b exp 0", a_udf); end
    endtask

    task automatic test_fwft;
        do_reset();
        b_wr  = 1'b1;
        b_din = 8'hA5;
        step();
        b_wr = 1'b0;
        tests_run++; if (b_dout !== 8'hA5 || b_dv !== 1'b1) begin failed++; $display("FAIL fwft_first: got %h/%b exp a5/1", b_dout, b_dv); end
        tests_run++; if (b_empty !== 1'b0 || b_cnt !== 5'd1) begin failed++; $display("FAIL fwft_count: got e=%b c=%0d exp 0 1", b_empty, b_cnt); end
        step();
        tests_run++; if (b_dout !== 8'hA5 || b_dv !== 1'b1) begin failed++; $display("FAIL fwft_hold: got %h/%b exp a5/1", b_dout, b_dv); end
        b_rd = 1'b1;
        step();
        b_rd = 1'b0;
        tests_run++; if (b_dv !== 1'b0 || b_empty !== 1'b1) begin failed++; $display("FAIL fwft_pop: got dv=%b e=%b exp 0 1", b_dv, b_empty); end
        for (int i = 1; i <= 3; i++) begin
            b_wr  = 1'b1;
            b_din = 8'(i);
            step();
        end
        b_wr = 1'b0;
        tests_run++; if (b_dout !== 8'd1 || b_cnt !== 5'd3) begin failed++; $display("FAIL fwft_head: got %h c=%0d exp 01 c=3", b_dout, b_cnt); end
        b_rd = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            tests_run++; if (b_dout !== 8'(k + 2) || b_dv !== 1'b1) begin failed++; $display("FAIL fwft_order[%0d]: got %h/%b exp %h/1", k, b_dout, b_dv, 8'(k + 2)); end
        end
        step();
        b_rd = 1'b0;
        tests_run++; if (b_dv !== 1'b0 || b_udf !== 1'b0) begin failed++; $display("FAIL fwft_drained: got dv=%b udf=%b exp 0 0", b_dv, b_udf); end
    endtask

    task automatic test_async_reset;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            a_wr  = 1'b1;
            a_din = 8'(8'h11 * i);
            step();
        end
        a_rd  = 1'b1;
        a_din = 8'h44;
        step();
        a_rd  = 1'b0;
        a_din = 8'h55;
        tests_run++; if (a_dout !== 8'h11) begin failed++; $display("FAIL async_pre: got %h exp 11", a_dout); end
        #3;
        rst = 1'b1;
        #1;
        tests_run++; if (a_cnt !== 5'd0 || a_empty !== 1'b1 || a_full !== 1'b0) begin failed++; $display("FAIL async_count: got c=%0d e=%b f=%b exp 0 1 0", a_cnt, a_empty, a_full); end
        tests_run++; if (a_dout !== 8'h00 || a_dv !== 1'b0) begin failed++; $display("FAIL async_dout: got %h/%b exp 00/0", a_dout, a_dv); end
        a_wr = 1'b0;
        step();
        rst = 1'b0;
        tests_run++; if (a_cnt !== 5'd0) begin failed++; $display("FAIL async_hold: got %0d exp 0", a_cnt); end
        a_wr  = 1'b1;
        a_din = 8'h3C;
        step();
        a_wr = 1'b0;
        a_rd = 1'b1;
        step();
        a_rd = 1'b0;
        tests_run++; if (a_dout !== 8'h3C || a_dv !== 1'b1 || a_cnt !== 5'd0) begin failed++; $display("FAIL async_after: got %h/%b c=%0d exp 3c/1 c=0", a_dout, a_dv, a_cnt); end
    endtask

    initial begin
        tests_run = 0;
        failed    = 0;
        rst   = 1'b0;
        a_wr  = 1'b0; a_rd = 1'b0; a_clr = 1'b0; a_din = 8'h00;
        b_wr  = 1'b0; b_rd = 1'b0; b_clr = 1'b0; b_din = 8'h00;
        test_reset();
        test_fill();
        test_drain_std();
        test_simul_wrap();
        test_err_simul();
        test_fwft();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/fifo_sync_ext.md
Name: fifo_sync_ext

Overview:
Parametrised single-clock FIFO, next generation of the core's buffering block. Uses the full storage depth (MEMORY_DEPTH entries). Adds a selectable first-word-fall-through read mode, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. Intended for UART/bus bridges and fetch/load queues inside the core.

Parameters:
DATA_WIDTH, 32, word width in bits (>=1)
MEMORY_DEPTH, 16, number of entries; power of two, >=2
FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through
AFULL_THRESH, 14, almost_full asserted when count >= AFULL_THRESH (1..MEMORY_DEPTH)
AEMPTY_THRESH, 2, almost_empty asserted when count <= AEMPTY_THRESH (0..MEMORY_DEPTH-1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset; asynchronous, active-high
wr  input  1  write request
din  input  DATA_WIDTH  write data
rd  input  1  read request (FWFT=1: pop/acknowledge of the word on dout)
dout  output  DATA_WIDTH  read data
dout_valid  output  1  dout holds a valid word (see Behaviour)
empty  output  1  count == 0
full  output  1  count == MEMORY_DEPTH
almost_empty  output  1  count <= AEMPTY_THRESH
almost_full  output  1  count >= AFULL_THRESH
count  output  $clog2(MEMORY_DEPTH)+1  entries currently stored, 0..MEMORY_DEPTH
overflow  output  1  sticky: a write was attempted while full
underflow  output  1  sticky: a read was attempted while empty
clr_err  input  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (async assert, sync-safe deassert handled upstream): read/write pointers, count, dout, dout_valid, overflow and underflow all go to 0. empty=1, full=0, almost_empty=1, almost_full=(AFULL_THRESH==0 ? n/a : 0). Memory contents are not reset.
- Pointers are $clog2(MEMORY_DEPTH)+1 bits wide. The MSB is a wrap bit; the low bits address storage. Both pointers wrap naturally modulo 2*MEMORY_DEPTH.
- All flags are combinational from count. count updates on the same edge as the accepted access.
- Accepted write: wr & !full, using full as it stands before the edge. On the edge: mem[wptr] <= din, wptr+1.
- Accepted read: rd & !empty, using empty as it stands before the edge. On the edge: rptr+1.
- count: +1 on an accepted write only; -1 on an accepted read only; unchanged when both or neither are accepted.
- Simultaneous wr & rd:
  - when full: the read is accepted and the write is rejected; overflow is set.
  - when empty: the write is accepted and the read is rejected; underflow is set. The new word is readable from the next cycle.
- overflow sets on wr & full; underflow sets on rd & empty. Both hold until clr_err or rst. If clr_err and a new error occur in the same cycle, set wins.
- FWFT=0:
  - On an accepted read, dout <= mem[rptr] on the edge, and dout_valid pulses high for exactly the following cycle. Read latency is 1 cycle.
  - Otherwise dout holds its last value and dout_valid=0.
- FWFT=1:
  - dout = mem[rptr] continuously and dout_valid = !empty. The head word is visible 1 cycle after the write edge that filled an empty FIFO.
  - rd while dout_valid consumes the head; the next word appears in the same cycle as the pointer advance.
- Write-to-empty-deassert latency is 1 edge in both modes.
- Full depth is usable: exactly MEMORY_DEPTH writes from empty raise full.
- Reset asserted mid-burst: state clears immediately (asynchronous). Words in flight are discarded, and the first access after deassert starts at address 0.

Test Plan:
1. Reset, then 16 writes (din=0..15, DEPTH=16) -> full=1 after the 16th edge, count=16, almost_full=1 from count 14. A 17th write sets overflow=1, and count stays 16.
2. FWFT=0: 16 reads from full -> dout=0..15, each valid one cycle after its rd, with dout_valid pulsed. empty=1 after the last read. An extra rd sets underflow=1 and dout holds 15.
3. Simultaneous wr/rd at count=5 for 20 cycles -> count stays 5, data order preserved, pointers wrap past 16 without loss.
4. FWFT=1: write 0xA5 into empty -> next cycle dout=0xA5, dout_valid=1 with no rd. Pulse rd -> dout_valid=0 and empty=1.
5. wr&rd while full -> read returns the oldest word, count goes 16->15, overflow=1. wr&rd while empty -> count goes 0->1, underflow=1. clr_err -> both flags 0.
6. Assert rst asynchronously mid-burst between edges -> count=0, empty=1, dout=0 immediately. After release, write 0x3C then read -> dout=0x3C.
